run_ctrl: RTL and testbench

Parametrised run controller for the single-cycle CPU, replacing the fixed free-running clock, reset and timeout arrangement with a synthesizable, programmable block. It sequences CPU reset, then counts run cycles. It ends the run on a CPU halt request or on a cycle-budget timeout, then issues a flush window for waveform or trace dump. It sits between the top-level clock/reset and the CPU core, and drives the CPU's active-low reset.

---
 rtl/run_ctrl_pkg.sv | 21 ++
 rtl/run_ctrl_downcnt.sv | 28 ++
 rtl/run_ctrl.sv | 105 ++++++++++
 tb/tb_run_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/run_ctrl_pkg.sv
// run_ctrl shared types and defaults.
// State encoding plus default timing constants.
package run_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HOLD  = 3'd1,
    S_RUN   = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int DEF_RST_CYCLES   = 4;
  localparam int DEF_FLUSH_CYCLES = 2;
  localparam int DEF_DEF_LIMIT    = 625;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/run_ctrl_downcnt.sv
// Loadable down-counter with zero flag.
// Shared by the reset-hold and flush windows.
module run_ctrl_downcnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= val;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/run_ctrl.sv
// Run controller: CPU reset hold, budgeted run,
// flush window for trace dump, then done.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int RST_CYCLES   = DEF_RST_CYCLES,
  parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES,
  parameter int DEF_LIMIT    = DEF_DEF_LIMIT
) (
  input  logic             Clk,
  input  logic             iReset,
  input  logic             iStart,
  input  logic             iHalt,
  input  logic [CNT_W-1:0] iLimit,
  output logic             oCpuReset,
  output logic             oRunning,
  output logic             oFlush,
  output logic             oDone,
  output logic             oTimeout,
  output logic [CNT_W-1:0] oCycles
);

  localparam int CMAX = max2(RST_CYCLES, FLUSH_CYCLES);
  localparam int DW   = (CMAX > 2) ? $clog2(CMAX) : 1;

  state_t         state, nxt;
  logic [CNT_W-1:0] limit;
  logic           start, ld, dec, zero, last, stop;
  logic [DW-1:0]  ldval;

  run_ctrl_downcnt #(.W(DW)) u_cnt (
    .clk   (Clk),
    .rst_n (iReset),
    .load  (ld),
    .dec   (dec),
    .val   (ldval),
    .zero  (zero)
  );

  assign last = (oCycles == limit - 1'b1);
  assign stop = iHalt || last;

  always_comb begin
    nxt   = state;
    start = 1'b0;
    ld    = 1'b0;
    dec   = 1'b0;
    ldval = '0;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (iStart) begin
          nxt   = S_HOLD;
          start = 1'b1;
          ld    = 1'b1;
          ldval = DW'(RST_CYCLES - 1);
        end
      end
      S_HOLD: begin
        if (zero) nxt = S_RUN;
        else      dec = 1'b1;
      end
      S_RUN: begin
        if (stop) begin
          nxt   = S_FLUSH;
          ld    = 1'b1;
          ldval = DW'(FLUSH_CYCLES - 1);
        end
      end
      S_FLUSH: begin
        if (zero) nxt = S_DONE;
        else      dec = 1'b1;
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge iReset) begin
    if (!iReset) begin
      state    <= S_IDLE;
      limit    <= CNT_W'(DEF_LIMIT);
      oCycles  <= '0;
      oTimeout <= 1'b0;
    end else begin
      state <= nxt;
      if (start) begin
        limit    <= (iLimit == '0) ? CNT_W'(DEF_LIMIT) : iLimit;
        oCycles  <= '0;
        oTimeout <= 1'b0;
      end
      if (state == S_RUN) begin
        oCycles <= oCycles + 1'b1;
        if (stop) oTimeout <= ~iHalt;
      end
    end
  end

  // CPU stays out of reset through flush/done so its state can be dumped.
  assign oCpuReset = (state == S_RUN) || (state == S_FLUSH)
                  || (state == S_DONE);
  assign oRunning  = (state == S_RUN);
  assign oFlush    = (state == S_FLUSH);
  assign oDone     = (state == S_DONE);

endmodule

// File: tb/tb_run_ctrl.sv
// Self-checking bench for run_ctrl: vector table,
// randomized runs vs. a phase-count model, async reset.
module tb_run_ctrl;

  localparam int CNT_W = 16;
  localparam int RSTC  = 4;
  localparam int FLC   = 2;
  localparam int DEFL  = 625;

  logic             Clk = 1'b0;
  logic             iReset = 1'b0;
  logic             iStart = 1'b0;
  logic             iHalt = 1'b0;
  logic [CNT_W-1:0] iLimit = '0;
  logic             oCpuReset, oRunning, oFlush, oDone, oTimeout;
  logic [CNT_W-1:0] oCycles;

  int checks = 0;
  int errors = 0;

  run_ctrl #(
    .CNT_W(CNT_W), .RST_CYCLES(RSTC),
    .FLUSH_CYCLES(FLC), .DEF_LIMIT(DEFL)
  ) dut (
    .Clk(Clk), .iReset(iReset), .iStart(iStart),
    .iHalt(iHalt), .iLimit(iLimit),
    .oCpuReset(oCpuReset), .oRunning(oRunning),
    .oFlush(oFlush), .oDone(oDone),
    .oTimeout(oTimeout), .oCycles(oCycles)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int lim;
    int halt_at;
    bit noise;
    int exp_run;
    int exp_to;
  } vec_t;

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  // Model: budget L (0 -> default); halt seen at run index h ends after h+1.
  function automatic void model(input int lim, input int h,
                                output int run, output int to);
    int l;
    l = (lim == 0) ? DEFL : lim;
    if (h >= 0 && h < l) begin
      run = h + 1;
      to  = 0;
    end else begin
      run = l;
      to  = 1;
    end
  endfunction

  task automatic run_txn(input string tag, input int lim,
                         input int h, input bit noise,
                         input int exp_run, input int exp_to);
    int nh, nr, nf, bad;
    bit done;
    nh = 0; nr = 0; nf = 0; bad = 0; done = 0;
    @(negedge Clk);
    iLimit = CNT_W'(lim);
    iStart = 1'b1;
    @(negedge Clk);
    iStart = 1'b0;
    chk({tag, "_done_clr"}, int'(oDone), 0);
    for (int k = 0; k < 5000; k++) begin
      if (oDone) begin
        done = 1;
        break;
      end
      if (!oCpuReset) nh++;
      if (oRunning) begin
        if (int'(oCycles) != nr) bad++;
        nr++;
      end
      if (oFlush) begin
        nf++;
        if (int'(oCycles) != exp_run) bad++;
      end
      if ((oFlush || oRunning) && !oCpuReset) bad++;
      iHalt = oCpuReset
            ? (oRunning && h >= 0 && int'(oCycles) == h)
            : 1'($urandom_range(0, 1));
      iStart = (noise && (oRunning || oFlush))
             ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge Clk);
    end
    iHalt  = 1'b0;
    iStart = 1'b0;
    chk({tag, "_bound"}, int'(done), 1);
    chk({tag, "_hold"}, nh, RSTC);
    chk({tag, "_run"}, nr, exp_run);
    chk({tag, "_flush"}, nf, FLC);
    chk({tag, "_seq"}, bad, 0);
    chk({tag, "_cycles"}, int'(oCycles), exp_run);
    chk({tag, "_timeout"}, int'(oTimeout), exp_to);
    chk({tag, "_cpurst"}, int'(oCpuReset), 1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cpurst"}, int'(oCpuReset), 0);
    chk({tag, "_running"}, int'(oRunning), 0);
    chk({tag, "_flush"}, int'(oFlush), 0);
    chk({tag, "_done"}, int'(oDone), 0);
    chk({tag, "_to"}, int'(oTimeout), 0);
    chk({tag, "_cyc"}, int'(oCycles), 0);
  endtask

  vec_t tbl[7];

  initial begin
    int r, t, l, h;
    tbl[0] = '{0, -1, 1'b0, 625, 1};
    tbl[1] = '{10, 3, 1'b0, 4, 0};
    tbl[2] = '{5, 4, 1'b0, 5, 0};
    tbl[3] = '{1, -1, 1'b1, 1, 1};
    tbl[4] = '{3, -1, 1'b1, 3, 1};
    tbl[5] = '{1, 0, 1'b1, 1, 0};
    tbl[6] = '{7, 9, 1'b1, 7, 1};

    #12;
    chk_reset_vals("por");
    @(negedge Clk);
    iReset = 1'b1;
    repeat (2) @(negedge Clk);
    chk("idle_cpurst", int'(oCpuReset), 0);

    foreach (tbl[i])
      run_txn($sformatf("vec%0d", i), tbl[i].lim, tbl[i].halt_at,
              tbl[i].noise, tbl[i].exp_run, tbl[i].exp_to);

    // Async reset in mid-RUN, checked before the next edge.
    @(negedge Clk);
    iLimit = 16'd50;
    iStart = 1'b1;
    @(negedge Clk);
    iStart = 1'b0;
    repeat (RSTC + 6) @(negedge Clk);
    chk("midrun_running", int'(oRunning), 1);
    @(posedge Clk);
    #2;
    iReset = 1'b0;
    #1;
    chk_reset_vals("async");
    @(negedge Clk);
    iReset = 1'b1;
    run_txn("after_rst", 6, -1, 1'b0, 6, 1);

    for (int n = 0; n < 20; n++) begin
      l = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 40));
      h = ($urandom_range(0, 2) == 0) ? -1
        : int'($urandom_range(0, 45));
      model(l, h, r, t);
      run_txn($sformatf("rnd%0d", n), l, h,
              1'($urandom_range(0, 1)), r, t);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
